// File: rtl/wca_rbus_fifo_port_if.sv
// Register-bus control and FIFO stream signals for wca_rbus_fifo_port.
// The irq member and its modport entries exist only when WCA_RBUS_FIFO_IRQ_EN is defined.
interface wca_rbus_fifo_port_if;
  logic [12:0] rbusCtrl;
  logic [15:0] tx_data;
  logic        tx_rd;
  logic        tx_empty;
  logic [15:0] rx_data;
  logic        rx_wr;
  logic        rx_full;
`ifdef WCA_RBUS_FIFO_IRQ_EN
  logic        irq;

  modport slave (
    input  rbusCtrl, tx_rd, rx_data, rx_wr,
    output tx_data, tx_empty, rx_full, irq
  );
  modport master (
    output rbusCtrl, tx_rd, rx_data, rx_wr,
    input  tx_data, tx_empty, rx_full, irq
  );
`else
  modport slave (
    input  rbusCtrl, tx_rd, rx_data, rx_wr,
    output tx_data, tx_empty, rx_full
  );
  modport master (
    output rbusCtrl, tx_rd, rx_data, rx_wr,
    input  tx_data, tx_empty, rx_full
  );
`endif
endinterface

// File: rtl/wca_rbus_fifo_port.sv
// Register-bus slave exposing a DATA/STATUS window backed by TX and RX FIFOs.
// Optional feature macro: WCA_RBUS_FIFO_IRQ_EN adds irq and the STATUS[7] irq_en register.
module wca_rbus_fifo_port #(
  parameter logic [7:0] ADDR       = 8'h20,
  parameter int         DEPTH_LOG2 = 4
) (
  input  logic                  cpuclock,
  input  logic                  reset,
  inout  wire  [15:0]           rbusData,
  wca_rbus_fifo_port_if.slave   bus
);
  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam int         PW     = DEPTH_LOG2 + 1;
  localparam logic [7:0] ADDR_S = ADDR + 8'd1;

  logic [7:0]    addr;
  logic          n_as, n_rs, n_ws;
  logic          unused_ctrl;
  logic [7:0]    areg_reg;
  logic          nrd_q_reg, nwr_q_reg;
  logic [15:0]   rdreg_reg;
  logic          tx_ovf_reg, rx_unf_reg;
  logic [15:0]   tx_mem [DEPTH];
  logic [15:0]   rx_mem [DEPTH];
  logic [PW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [PW-1:0] tx_cnt, rx_cnt;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          sel_d, sel_s, wr_ev, rd_end, drive;
  logic          tx_push_req, tx_push, tx_pop, tx_flush, tx_ovf_set;
  logic          rx_push, rx_pop, rx_flush, rx_unf_set, stat_clr;
  logic          irq_en_bit;
  logic [15:0]   rx_head, status;

  assign addr        = bus.rbusCtrl[11:4];
  assign n_as        = bus.rbusCtrl[3];
  assign n_rs        = bus.rbusCtrl[2];
  assign n_ws        = bus.rbusCtrl[1];
  assign unused_ctrl = bus.rbusCtrl[12] ^ bus.rbusCtrl[0];

  assign sel_d  = (areg_reg == ADDR);
  assign sel_s  = (areg_reg == ADDR_S);
  assign wr_ev  = nwr_q_reg & ~n_ws;
  // A write event in the same cycle masks the read-end.
  assign rd_end = ~nrd_q_reg & n_rs & ~wr_ev;

  // Count reaches DEPTH only when full, so its MSB alone flags full.
  assign tx_cnt   = tx_wr_ptr_reg - tx_rd_ptr_reg;
  assign rx_cnt   = rx_wr_ptr_reg - rx_rd_ptr_reg;
  assign tx_empty = (tx_cnt == '0);
  assign rx_empty = (rx_cnt == '0);
  assign tx_full  = tx_cnt[PW-1];
  assign rx_full  = rx_cnt[PW-1];

  assign tx_flush    = wr_ev & sel_s & rbusData[1];
  assign rx_flush    = wr_ev & sel_s & rbusData[0];
  assign tx_pop      = bus.tx_rd & ~tx_empty & ~tx_flush;
  assign tx_push_req = wr_ev & sel_d;
  assign tx_push     = tx_push_req & (~tx_full | tx_pop) & ~tx_flush;
  assign tx_ovf_set  = tx_push_req & tx_full & ~tx_pop;
  assign rx_pop      = rd_end & sel_d & ~rx_empty & ~rx_flush;
  assign rx_push     = bus.rx_wr & (~rx_full | rx_pop) & ~rx_flush;
  assign rx_unf_set  = rd_end & sel_d & rx_empty;
  assign stat_clr    = rd_end & sel_s;

  assign rx_head = rx_empty ? 16'h0000 : rx_mem[rx_rd_ptr_reg[PW-2:0]];
  assign status  = {8'(rx_cnt), irq_en_bit, 1'b0, rx_unf_reg, tx_ovf_reg,
                    tx_full, tx_empty, rx_full, rx_empty};

  assign bus.tx_data  = tx_empty ? 16'h0000 : tx_mem[tx_rd_ptr_reg[PW-2:0]];
  assign bus.tx_empty = tx_empty;
  assign bus.rx_full  = rx_full;

  // Gating with reset releases the bus the instant reset asserts.
  assign drive    = reset & ~n_rs & (sel_d | sel_s);
  assign rbusData = drive ? rdreg_reg : 16'bz;

  always_ff @(posedge cpuclock or negedge reset) begin
    if (!reset) begin
      areg_reg      <= '0;
      nrd_q_reg     <= 1'b1;
      nwr_q_reg     <= 1'b1;
      rdreg_reg     <= '0;
      tx_ovf_reg    <= 1'b0;
      rx_unf_reg    <= 1'b0;
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
    end else begin
      if (!n_as) areg_reg <= addr;
      nrd_q_reg <= n_rs;
      nwr_q_reg <= n_ws;
      rdreg_reg <= sel_s ? status : rx_head;

      if (tx_flush) begin
        tx_rd_ptr_reg <= tx_wr_ptr_reg;
      end else begin
        if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
        if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
      end

      if (rx_flush) begin
        rx_rd_ptr_reg <= rx_wr_ptr_reg;
      end else begin
        if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
        if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
      end

      if (tx_ovf_set)    tx_ovf_reg <= 1'b1;
      else if (stat_clr) tx_ovf_reg <= 1'b0;
      if (rx_unf_set)    rx_unf_reg <= 1'b1;
      else if (stat_clr) rx_unf_reg <= 1'b0;
    end
  end

  always_ff @(posedge cpuclock) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg[PW-2:0]] <= rbusData;
    if (rx_push) rx_mem[rx_wr_ptr_reg[PW-2:0]] <= bus.rx_data;
  end

`ifdef WCA_RBUS_FIFO_IRQ_EN
  logic irq_en_reg, irq_reg;

  always_ff @(posedge cpuclock or negedge reset) begin
    if (!reset) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr_ev && sel_s) irq_en_reg <= rbusData[7];
      irq_reg <= irq_en_reg & (~rx_empty | tx_ovf_reg | rx_unf_reg);
    end
  end

  assign irq_en_bit = irq_en_reg;
  assign bus.irq    = irq_reg;
`else
  assign irq_en_bit = 1'b0;
`endif
endmodule
